// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: peripheral req/ack bus between the LSU and the device fabric
interface mem_stage_lsu_if #(
  parameter int NUM_DEV = 2
);
  logic               req;
  logic               we;
  logic [NUM_DEV-1:0] sel;
  logic [29:0]        addr;
  logic [31:0]        wdata;
  logic               ack;
  logic [31:0]        rdata;
  modport master (output req, we, sel, addr, wdata, input ack, rdata);
  modport slave (input req, we, sel, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with DM window, device windows and a timed peripheral handshake
module mem_stage_lsu #(
  parameter logic [31:0] DM_TOP     = 32'h0000_2ffc,
  parameter int          NUM_DEV    = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h10,
  parameter int          DEV_SPAN   = 12,
  parameter int          RO_OFFSET  = 8,
  parameter int          TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        kill_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        exc_valid_o,
  output logic [4:0]  exc_code_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic [31:0] dm_rdata_i,
  mem_stage_lsu_if.master pr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic buserr_q, buserr_d, we_q, we_d;
  logic [31:0] data_q, data_d, wdata_q, wdata_d;
  logic [29:0] addr_q, addr_d;
  logic [NUM_DEV-1:0] sel_q, sel_d, in_dev, ro_hit;
  logic op_lw, op_lh, op_lhu, op_lb, op_lbu, op_sw, op_sh, op_sb;
  logic is_load, is_store, sub_ld, in_dm, dev, none, adel, ades, exc, dev_go;
  logic [31:0] word;
  logic [15:0] half;
  logic [7:0] byt;
  for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
    localparam logic [31:0] BASE = DEV_BASE + 32'(i) * DEV_STRIDE;
    assign in_dev[i] = addr_i >= BASE && addr_i <= BASE + 32'(DEV_SPAN - 1);
    assign ro_hit[i] = addr_i == BASE + 32'(RO_OFFSET);
  end
  assign op_lw = mem_op_i == 4'd1;
  assign op_lh = mem_op_i == 4'd2;
  assign op_lhu = mem_op_i == 4'd3;
  assign op_lb = mem_op_i == 4'd4;
  assign op_lbu = mem_op_i == 4'd5;
  assign op_sw = mem_op_i == 4'd6;
  assign op_sh = mem_op_i == 4'd7;
  assign op_sb = mem_op_i == 4'd8;
  assign sub_ld = op_lh | op_lhu | op_lb | op_lbu;
  assign is_load = op_lw | sub_ld;
  assign is_store = op_sw | op_sh | op_sb;
  assign in_dm = ~addr_i[31] && addr_i <= DM_TOP;
  assign dev = |in_dev;
  assign none = ~in_dm & ~dev;
  assign adel = is_load & ((op_lw & |addr_i[1:0]) | ((op_lh | op_lhu) & addr_i[0]) | (sub_ld & dev) | none);
  assign ades = is_store & ((op_sw & |addr_i[1:0]) | (op_sh & addr_i[0]) | ((op_sh | op_sb) & dev) | (op_sw & |ro_hit) | none);
  assign exc = adel | ades;
  assign dev_go = (is_load | is_store) & dev & ~exc & ~kill_i;
  // Reset forces the pipe-facing status quiet even while the inputs still show a device access.
  assign stall_o = reset & (state_q == S_WAIT || (state_q == S_IDLE && dev_go));
  assign exc_valid_o = reset & (state_q == S_IDLE ? exc : (state_q == S_DONE && buserr_q));
  assign exc_code_o = !exc_valid_o ? 5'd0 : state_q == S_DONE ? 5'd7 : adel ? 5'd4 : 5'd5;
  assign dm_we_o = is_store & in_dm & ~exc & ~kill_i;
  assign dm_be_o = op_sw ? 4'b1111 : op_sh ? 4'b0011 << addr_i[1:0] : op_sb ? 4'b0001 << addr_i[1:0] : 4'b0000;
  assign dm_addr_o = {addr_i[31:2], 2'b00};
  assign dm_wdata_o = op_sh ? {2{wdata_i[15:0]}} : op_sb ? {4{wdata_i[7:0]}} : wdata_i;
  assign word = state_q == S_DONE ? data_q : dm_rdata_i;
  assign half = addr_i[1] ? word[31:16] : word[15:0];
  assign byt = addr_i[1] ? (addr_i[0] ? word[31:24] : word[23:16]) : (addr_i[0] ? word[15:8] : word[7:0]);
  assign rdata_o = op_lw ? word : op_lh ? {{16{half[15]}}, half} : op_lhu ? {16'b0, half} :
                   op_lb ? {{24{byt[7]}}, byt} : op_lbu ? {24'b0, byt} : 32'b0;
  assign pr.req = state_q == S_WAIT;
  assign pr.we = we_q;
  assign pr.sel = sel_q;
  assign pr.addr = addr_q;
  assign pr.wdata = wdata_q;
  // Peripheral transaction sequencing: issue, wait for ack or timeout, deliver for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buserr_d = buserr_q;
    data_d = data_q;
    sel_d = sel_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (dev_go) begin
        state_d = S_WAIT;
        cnt_d = '0;
        sel_d = in_dev;
        we_d = is_store;
        addr_d = addr_i[31:2];
        wdata_d = wdata_i;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (pr.ack || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          buserr_d = ~pr.ack;
          data_d = pr.ack ? pr.rdata : data_q;
          sel_d = '0;
          we_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d = '0;
        buserr_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State and latched bus registers; async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      buserr_q <= 1'b0;
      data_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buserr_q <= buserr_d;
      data_q <= data_d;
      sel_q <= sel_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for the MEM-stage load/store unit
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] mem_op;
  logic [31:0] addr, wdata, dm_rdata, rdata, dm_addr, dm_wdata;
  logic kill, stall, exc_valid, dm_we;
  logic [4:0] exc_code;
  logic [3:0] dm_be;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.NUM_DEV(2)) pr ();

  mem_stage_lsu dut (
    .clk(clk), .reset(reset), .mem_op_i(mem_op), .addr_i(addr), .wdata_i(wdata), .kill_i(kill),
    .stall_o(stall), .rdata_o(rdata), .exc_valid_o(exc_valid), .exc_code_o(exc_code),
    .dm_we_o(dm_we), .dm_be_o(dm_be), .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata),
    .dm_rdata_i(dm_rdata), .pr(pr)
  );

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] d, input logic k);
    @(negedge clk);
    mem_op = op;
    addr = a;
    wdata = w;
    dm_rdata = d;
    kill = k;
    #1;
  endtask

  task automatic run_dev(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                         input int ack_after, input logic [31:0] rv,
                         output int stalls, output logic [1:0] sel, output logic we,
                         output logic [29:0] pa, output logic [31:0] pw, output logic [31:0] rd,
                         output logic ev, output logic [4:0] ec, output logic to);
    int waits = 0;
    stalls = 0;
    sel = '0;
    we = 1'b0;
    pa = '0;
    pw = '0;
    to = 1'b0;
    pr.rdata = rv;
    drive(op, a, w, 32'h0, 1'b0);
    while (stall) begin
      if (stalls > 100) begin
        to = 1'b1;
        break;
      end
      stalls++;
      if (pr.req && waits == 0) begin
        sel = pr.sel;
        we = pr.we;
        pa = pr.addr;
        pw = pr.wdata;
      end
      pr.ack = pr.req && waits == ack_after;
      if (pr.req) waits++;
      @(negedge clk);
      pr.ack = 1'b0;
      #1;
    end
    rd = rdata;
    ev = exc_valid;
    ec = exc_code;
  endtask

  task automatic test_reset;
    drive(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if ({stall, exc_valid, exc_code, dm_we, pr.req, pr.we, pr.sel, pr.addr, pr.wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", {stall, exc_valid, exc_code, dm_we, pr.req, pr.we, pr.sel, pr.addr, pr.wdata});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_dm_store;
    logic [3:0]  op_t [3] = '{4'd8, 4'd7, 4'd6};
    logic [31:0] a_t [3] = '{32'h102, 32'h2, 32'h2ffc};
    logic [31:0] w_t [3] = '{32'h0000_00a5, 32'h1234_beef, 32'hdead_beef};
    logic [3:0]  be_t [3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] da_t [3] = '{32'h100, 32'h0, 32'h2ffc};
    logic [31:0] dw_t [3] = '{32'ha5a5_a5a5, 32'hbeef_beef, 32'hdead_beef};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back('{1'b0, 32'h0, 1'b0, 5'd0});
      drive(op_t[i], a_t[i], w_t[i], 32'h0, 1'b0);
      e = sbq.pop_front();
      n_cmp++;
      if ({stall, exc_valid, exc_code, dm_we, dm_be, dm_addr, dm_wdata} !==
          {1'b0, e.exc, e.code, 1'b1, be_t[i], da_t[i], dw_t[i]}) begin
        n_bad++;
        $display("FAIL dm_store[%0d]: got stall=%b exc=%b code=%0d we=%b be=%b addr=%h wdata=%h want be=%b addr=%h wdata=%h",
                 i, stall, exc_valid, exc_code, dm_we, dm_be, dm_addr, dm_wdata, be_t[i], da_t[i], dw_t[i]);
      end
    end
  endtask

  task automatic test_dm_load;
    logic [3:0]  op_t [8] = '{4'd4, 4'd5, 4'd2, 4'd3, 4'd2, 4'd1, 4'd4, 4'd5};
    logic [31:0] a_t [8] = '{32'h102, 32'h102, 32'h2, 32'h2, 32'h0, 32'h2ff8, 32'h3, 32'h1};
    logic [31:0] d_t [8] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_7ffe, 32'h8001_7ffe,
                             32'h8001_7ffe, 32'h8001_7ffe, 32'h8001_7ffe, 32'h8001_7ffe};
    logic [31:0] r_t [8] = '{32'hffff_ff80, 32'h0000_0080, 32'hffff_8001, 32'h0000_8001,
                             32'h0000_7ffe, 32'h8001_7ffe, 32'hffff_ff80, 32'h0000_007f};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      sbq.push_back('{1'b1, r_t[i], 1'b0, 5'd0});
      drive(op_t[i], a_t[i], 32'h0, d_t[i], 1'b0);
      e = sbq.pop_front();
      n_cmp++;
      if ({stall, exc_valid, exc_code, dm_we, rdata} !== {1'b0, e.exc, e.code, 1'b0, e.rdata}) begin
        n_bad++;
        $display("FAIL dm_load[%0d]: got stall=%b exc=%b code=%0d we=%b rdata=%h want rdata=%h",
                 i, stall, exc_valid, exc_code, dm_we, rdata, e.rdata);
      end
    end
  endtask

  task automatic test_exc;
    logic [3:0]  op_t [11] = '{4'd2, 4'd6, 4'd6, 4'd1, 4'd1, 4'd4, 4'd7, 4'd6, 4'd8, 4'd7, 4'd1};
    logic [31:0] a_t [11] = '{32'h3, 32'h7f08, 32'h7f18, 32'h2, 32'h3000, 32'h7f00, 32'h7f10,
                              32'h7f0c, 32'h8000_0000, 32'h1, 32'h7f20};
    logic [4:0]  c_t [11] = '{5'd4, 5'd5, 5'd5, 5'd4, 5'd4, 5'd4, 5'd5, 5'd5, 5'd5, 5'd5, 5'd4};
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      sbq.push_back('{1'b0, 32'h0, 1'b1, c_t[i]});
      drive(op_t[i], a_t[i], 32'hffff_ffff, 32'h0, 1'b0);
      e = sbq.pop_front();
      n_cmp++;
      if ({stall, exc_valid, exc_code, dm_we, pr.req} !== {1'b0, e.exc, e.code, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL exc[%0d]: got stall=%b exc=%b code=%0d we=%b req=%b want exc=1 code=%0d",
                 i, stall, exc_valid, exc_code, dm_we, pr.req, e.code);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({pr.req, stall} !== 2'b00) begin
        n_bad++;
        $display("FAIL exc_noreq[%0d]: got req=%b stall=%b want 0 0", i, pr.req, stall);
      end
    end
  endtask

  task automatic test_kill;
    exp_t e;
    sbq.push_back('{1'b0, 32'h0, 1'b0, 5'd0});
    drive(4'd6, 32'h10, 32'h1111_2222, 32'h0, 1'b1);
    e = sbq.pop_front();
    n_cmp++;
    if ({stall, exc_valid, exc_code, dm_we} !== {1'b0, e.exc, e.code, 1'b0}) begin
      n_bad++;
      $display("FAIL kill_dm: got stall=%b exc=%b code=%0d we=%b want 0 0 0 0", stall, exc_valid, exc_code, dm_we);
    end
    sbq.push_back('{1'b0, 32'h0, 1'b0, 5'd0});
    drive(4'd6, 32'h7f00, 32'h1111_2222, 32'h0, 1'b1);
    e = sbq.pop_front();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({stall, exc_valid, exc_code, pr.req} !== {1'b0, e.exc, e.code, 1'b0}) begin
      n_bad++;
      $display("FAIL kill_dev: got stall=%b exc=%b code=%0d req=%b want 0 0 0 0", stall, exc_valid, exc_code, pr.req);
    end
    kill = 1'b0;
  endtask

  task automatic test_dev;
    int st;
    logic [1:0] sel;
    logic we, ev, to;
    logic [29:0] pa;
    logic [31:0] pw, rd;
    logic [4:0] ec;
    exp_t e;
    sbq.push_back('{1'b1, 32'h0000_1234, 1'b0, 5'd0});
    run_dev(4'd1, 32'h7f14, 32'h0, 3, 32'h0000_1234, st, sel, we, pa, pw, rd, ev, ec, to);
    e = sbq.pop_front();
    n_cmp++;
    if ({to, st, sel, we, pa, rd, ev, ec, pr.req} !== {1'b0, 32'd5, 2'b10, 1'b0, 30'h1fc5, e.rdata, e.exc, e.code, 1'b0}) begin
      n_bad++;
      $display("FAIL dev_lw: got to=%b stall=%0d sel=%b we=%b addr=%h rdata=%h exc=%b code=%0d req=%b want stall=5 sel=10 addr=1fc5 rdata=%h",
               to, st, sel, we, pa, rd, ev, ec, pr.req, e.rdata);
    end
    sbq.push_back('{1'b0, 32'h0, 1'b0, 5'd0});
    run_dev(4'd6, 32'h7f04, 32'hcafe_f00d, 0, 32'h0, st, sel, we, pa, pw, rd, ev, ec, to);
    e = sbq.pop_front();
    n_cmp++;
    if ({to, st, sel, we, pa, pw, ev, ec} !== {1'b0, 32'd2, 2'b01, 1'b1, 30'h1fc1, 32'hcafe_f00d, e.exc, e.code}) begin
      n_bad++;
      $display("FAIL dev_sw: got to=%b stall=%0d sel=%b we=%b addr=%h wdata=%h exc=%b code=%0d want stall=2 sel=01 we=1 addr=1fc1 wdata=cafef00d",
               to, st, sel, we, pa, pw, ev, ec);
    end
    sbq.push_back('{1'b1, 32'h0bad_cafe, 1'b0, 5'd0});
    run_dev(4'd1, 32'h7f08, 32'h0, 14, 32'h0bad_cafe, st, sel, we, pa, pw, rd, ev, ec, to);
    e = sbq.pop_front();
    n_cmp++;
    if ({to, st, rd, ev, ec} !== {1'b0, 32'd16, e.rdata, e.exc, e.code}) begin
      n_bad++;
      $display("FAIL dev_ack_at_limit: got to=%b stall=%0d rdata=%h exc=%b code=%0d want stall=16 rdata=%h exc=0",
               to, st, rd, ev, ec, e.rdata);
    end
  endtask

  task automatic test_timeout;
    int st;
    logic [1:0] sel;
    logic we, ev, to;
    logic [29:0] pa;
    logic [31:0] pw, rd;
    logic [4:0] ec;
    exp_t e;
    sbq.push_back('{1'b0, 32'h0, 1'b1, 5'd7});
    run_dev(4'd1, 32'h7f00, 32'h0, -1, 32'h0, st, sel, we, pa, pw, rd, ev, ec, to);
    e = sbq.pop_front();
    n_cmp++;
    if ({to, st, ev, ec} !== {1'b0, 32'd16, e.exc, e.code}) begin
      n_bad++;
      $display("FAIL timeout: got to=%b stall=%0d exc=%b code=%0d want stall=16 exc=1 code=7", to, st, ev, ec);
    end
    drive(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    pr.ack = 1'b1;
    n_cmp++;
    if ({stall, exc_valid, pr.req} !== 3'b000) begin
      n_bad++;
      $display("FAIL timeout_idle: got stall=%b exc=%b req=%b want 0 0 0", stall, exc_valid, pr.req);
    end
    sbq.push_back('{1'b1, 32'h0000_0077, 1'b0, 5'd0});
    drive(4'd1, 32'h10, 32'h0, 32'h0000_0077, 1'b0);
    pr.ack = 1'b0;
    e = sbq.pop_front();
    n_cmp++;
    if ({stall, exc_valid, exc_code, rdata, pr.req} !== {1'b0, e.exc, e.code, e.rdata, 1'b0}) begin
      n_bad++;
      $display("FAIL after_timeout_dm: got stall=%b exc=%b code=%0d rdata=%h req=%b want rdata=%h",
               stall, exc_valid, exc_code, rdata, pr.req, e.rdata);
    end
  endtask

  task automatic test_back_to_back;
    int st;
    logic [1:0] sel;
    logic we, ev, to;
    logic [29:0] pa;
    logic [31:0] pw, rd;
    logic [4:0] ec;
    int ack_t [2] = '{1, 2};
    logic [31:0] a_t [2] = '{32'h7f10, 32'h7f00};
    logic [31:0] r_t [2] = '{32'h0000_0011, 32'h0000_0022};
    logic [1:0] s_t [2] = '{2'b10, 2'b01};
    exp_t e;
    for (int i = 0; i < 2; i++) sbq.push_back('{1'b1, r_t[i], 1'b0, 5'd0});
    for (int i = 0; i < 2; i++) begin
      run_dev(4'd1, a_t[i], 32'h0, ack_t[i], r_t[i], st, sel, we, pa, pw, rd, ev, ec, to);
      e = sbq.pop_front();
      n_cmp++;
      if ({to, st, sel, rd, ev, ec} !== {1'b0, 32'(ack_t[i] + 2), s_t[i], e.rdata, e.exc, e.code}) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got to=%b stall=%0d sel=%b rdata=%h exc=%b want stall=%0d sel=%b rdata=%h",
                 i, to, st, sel, rd, ev, ack_t[i] + 2, s_t[i], e.rdata);
      end
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    drive(4'd1, 32'h7f04, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (pr.req !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_enter_wait: got req=%b want 1", pr.req);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pr.req, stall, exc_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL abort_reset: got req=%b stall=%b exc=%b want 0 0 0", pr.req, stall, exc_valid);
    end
    mem_op = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    sbq.push_back('{1'b1, 32'h0000_55aa, 1'b0, 5'd0});
    drive(4'd1, 32'h2ff8, 32'h0, 32'h0000_55aa, 1'b0);
    e = sbq.pop_front();
    n_cmp++;
    if ({stall, exc_valid, rdata, pr.req} !== {1'b0, e.exc, e.rdata, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_then_dm: got stall=%b exc=%b rdata=%h req=%b want stall=0 rdata=%h",
               stall, exc_valid, rdata, pr.req, e.rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_op = 4'd0;
    addr = '0;
    wdata = '0;
    dm_rdata = '0;
    kill = 1'b0;
    pr.ack = 1'b0;
    pr.rdata = '0;
    test_reset;
    test_dm_store;
    test_dm_load;
    test_exc;
    test_kill;
    test_dev;
    test_timeout;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
